dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the MEM stage. It consumes the EX/MEM latch outputs: memory address, store data, and the 2-bit MemRead/MemWrite control.
- Models a multi-cycle word-addressed data memory. It stalls the pipeline for a configurable number of cycles per access.
- Returns load data to the MEM/WB latch and commits stores.
- Sits between the EX/MEM pipeline register and MEM/WB. Its stall output feeds the hazard unit, which freezes PC, IF/ID, ID/EX and EX/MEM.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two.
LATENCY, 3, stall cycles per access; legal range 1..15.

Ports:
clk_i  input  1  clock; all state updates on posedge.
rst_i  input  1  reset; synchronous, active-high.
mem_i  input  2  {MemRead, MemWrite} from EX/MEM; bit1 = read, bit0 = write.
addr_i  input  32  byte address (EX/MEM ALU result).
wdata_i  input  32  store data (EX/MEM rs2 data).
rdata_o  output  32  load data; valid in DONE; holds afterwards.
stall_o  output  1  freeze request to the hazard unit.
done_o  output  1  one-cycle pulse marking access completion.
misalign_o  output  1  pulse with done_o when addr_i[1:0] != 0.
err_o  output  1  pulse with done_o when both mem_i bits are set.

Behaviour:
- Reset (rst_i high at posedge):
  - state = IDLE, counter = 0.
  - rdata_o = 0, done_o = 0, misalign_o = 0, err_o = 0.
  - stall_o = 0 during the reset cycle.
  - Array contents are not cleared.
  - Reset in BUSY or DONE aborts the access; a pending store is not committed.
- Request = mem_i != 0. The EX/MEM latch holds its inputs stable while stall_o = 1.
- Index = addr_i[log2(DEPTH_WORDS)+1:2]. Higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Low two address bits are ignored for the access and reported via misalign_o.
- State IDLE:
  - stall_o = request, combinational.
  - On request: go to DONE if LATENCY = 1; otherwise go to BUSY and load counter = LATENCY-2.
  - With no request: stay in IDLE, stall_o = 0.
- State BUSY:
  - stall_o = 1.
  - counter == 0 → DONE; otherwise decrement the counter.
- State DONE:
  - stall_o = 0, done_o = 1; misalign_o and err_o are valid here.
  - Read: rdata_o registered from the array so it is valid throughout the DONE cycle. The array is read at the BUSY→DONE (or IDLE→DONE) edge.
  - Write: the array is written at the posedge ending DONE. Inputs are still the held values at that edge.
  - Always goes to IDLE next. The pipeline advances at that same edge, so the next request is first seen in IDLE one cycle later. No back-to-back re-trigger on stale inputs.
- Latency: a request first seen at cycle T is stalled for cycles T..T+LATENCY-1, completes in DONE at T+LATENCY, and the next request is seen at T+LATENCY+1.
- Both bits set: treated as a write (write has priority); err_o pulses in DONE; rdata_o unchanged.
- Outside DONE: rdata_o holds the last loaded value; it is not updated on writes.
- Read after write to the same index in consecutive accesses returns the new data.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_cnt_o, wr_cnt_o, stall_cnt_o, each 32 bits.
  - rd_cnt_o and wr_cnt_o increment on done_o for reads and writes respectively; an err_o access counts as a write.
  - stall_cnt_o increments every cycle stall_o = 1.
  - All three reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - MEM_READ_BIT = 1, MEM_WRITE_BIT = 0.
  - Word width constant 32.
  - Counter width 4.
- Sub-module dmem_array:
  - Single-port synchronous RAM, DEPTH_WORDS x 32.
  - Write-enable and registered read data.
  - No reset on contents.

Test Plan:
1. Reset, then mem_i = 2'b01, addr 0x10, data 0xDEADBEEF with LATENCY = 3 → stall_o high exactly 3 cycles; done_o pulses on cycle 4; then mem_i = 2'b10, addr 0x10 → rdata_o = 0xDEADBEEF in DONE.
2. LATENCY = 1: load from addr 0x0 → stall_o high 1 cycle, done_o on the next cycle; idle cycle follows before the next request is accepted.
3. Store to addr 0x3FC and to 0x7FC with DEPTH_WORDS = 256 (store values 0x11111111 then 0x22222222) → both map to index 255; a later load from 0x3FC returns 0x22222222.
4. Load from addr 0x13 → misalign_o = 1 with done_o; data equals the word at 0x10.
5. mem_i = 2'b11, addr 0x20, data 0x5A5A5A5A → err_o pulses; store is committed; rdata_o unchanged.
6. rst_i asserted in BUSY of a store of 0xCAFEF00D to addr 0x40 → stall_o = 0 next cycle, state IDLE; a later load from 0x40 returns the prior value. With DMEM_STATS_EN, all counters are 0 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Holds the FSM state encoding, mem_i bit positions, word and counter widths.
package dmem_pkg;

    localparam int WORD_W        = 32;
    localparam int CNT_W         = 4;
    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write enable and registered read data.
// Ports: clk_i, rst_i (clears only the read register), we_i, re_i, idx_i,
// wdata_i, rdata_o. Array contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= r_mem[idx_i];
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage multi-cycle data-memory responder: stalls the pipeline LATENCY
// cycles per access, returns load data, commits stores at the end of DONE.
// Ports: clk_i, rst_i, mem_i {read,write}, addr_i, wdata_i -> rdata_o,
// stall_o, done_o, misalign_o, err_o. Macro DMEM_STATS_EN adds rd_cnt_o,
// wr_cnt_o and stall_cnt_o access/stall counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mem_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              err_o
`ifdef DMEM_STATS_EN
    ,
    output logic [WORD_W-1:0] rd_cnt_o,
    output logic [WORD_W-1:0] wr_cnt_o,
    output logic [WORD_W-1:0] stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_stall;
    logic             w_enter_done;
    logic             w_req;
    logic             w_is_write;
    logic             w_is_read;
    logic             w_we;
    logic             w_re;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_addr;

    assign w_req      = |mem_i;
    // Write wins when both control bits are set.
    assign w_is_write = mem_i[MEM_WRITE_BIT];
    assign w_is_read  = mem_i[MEM_READ_BIT] & ~w_is_write;
    assign w_idx      = addr_i[IDX_W+1:2];

    assign w_unused_addr = ^addr_i[WORD_W-1:IDX_W+2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_enter_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    if (LATENCY == 1) begin
                        w_next       = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next     = BUSY;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_next       = DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            DONE: begin
                // Pipeline advances on this edge; never re-trigger on held inputs.
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Reset in any state aborts the access: no stall, no commit, no load.
    assign stall_o = w_stall & ~rst_i;
    assign w_re    = w_enter_done & w_is_read & ~rst_i;
    assign w_we    = (r_state == DONE) & w_is_write & ~rst_i;

    assign done_o     = (r_state == DONE);
    assign misalign_o = done_o & (|addr_i[1:0]);
    assign err_o      = done_o & (&mem_i);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_we),
        .re_i    (w_re),
        .idx_i   (w_idx),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );

`ifdef DMEM_STATS_EN
    logic [WORD_W-1:0] r_rd_cnt;
    logic [WORD_W-1:0] r_wr_cnt;
    logic [WORD_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (done_o && w_is_read) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (done_o && w_is_write) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (stall_o) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign rd_cnt_o    = r_rd_cnt;
    assign wr_cnt_o    = r_wr_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized loads/stores against a
// word-array reference model, plus directed wrap, misalign, err, abort cases.
module tb_dmem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [1:0]  mem_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        done_o;
    logic        misalign_o;
    logic        err_o;

    logic        rst1;
    logic [1:0]  mem1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        stall1;
    logic        done1;
    logic        mis1;
    logic        err1;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_o;
    logic [31:0] wr_cnt_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] rd_cnt1;
    logic [31:0] wr_cnt1;
    logic [31:0] stall_cnt1;
`endif

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .mem_i      (mem_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .misalign_o (misalign_o),
        .err_o      (err_o)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt_o),
        .wr_cnt_o    (wr_cnt_o),
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (1)
    ) dut1 (
        .clk_i      (clk),
        .rst_i      (rst1),
        .mem_i      (mem1),
        .addr_i     (addr1),
        .wdata_i    (wdata1),
        .rdata_o    (rdata1),
        .stall_o    (stall1),
        .done_o     (done1),
        .misalign_o (mis1),
        .err_o      (err1)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt1),
        .wr_cnt_o    (wr_cnt1),
        .stall_cnt_o (stall_cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array indexed modulo DEPTH.
    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_known [DEPTH];
    logic [31:0] mdl_rdata;
    bit          mdl_rdata_known;
    int          mdl_rd;
    int          mdl_wr;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] rdata;
        bit          rd_known;
        bit          misalign;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   stall_seen;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT reports completion.
    initial begin
        exp_t e;
        stall_seen = 0;
        mdl_rd = 0;
        mdl_wr = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                stall_seen = 0;
                mdl_rd = 0;
                mdl_wr = 0;
            end else begin
                if (stall_o) stall_seen++;
                if (done_o) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got 1 expected 0");
                    end else begin
                        e = q.pop_front();
                        chk("stall_len", stall_seen, LAT);
                        chk("misalign", 32'(misalign_o), 32'(e.misalign));
                        chk("err", 32'(err_o), 32'(e.err));
                        chk("stall_in_done", 32'(stall_o), 32'd0);
                        if (e.rd_known) chk("rdata", rdata_o, e.rdata);
                        if (e.op[0]) mdl_wr++;
                        else mdl_rd++;
                    end
                    stall_seen = 0;
                end
            end
        end
    end

    // Called at posedge+1; leaves inputs idle at posedge+1 after DONE ends.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        int   idx;
        bit   got;
        idx = int'((a >> 2) % DEPTH);
        e.op = op;
        e.misalign = (a[1:0] != 2'b00);
        e.err = (op == 2'b11);
        if (op[0]) begin
            mdl_mem[idx] = d;
            mdl_known[idx] = 1'b1;
            e.rdata = mdl_rdata;
            e.rd_known = mdl_rdata_known;
        end else begin
            e.rdata = mdl_mem[idx];
            e.rd_known = mdl_known[idx];
            mdl_rdata = mdl_mem[idx];
            mdl_rdata_known = mdl_known[idx];
        end
        q.push_back(e);
        mem_i = op;
        addr_i = a;
        wdata_i = d;
        got = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        mem_i = 2'b00;
        addr_i = $urandom;
        wdata_i = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;
        mdl_rdata = 32'h0;
        mdl_rdata_known = 1'b1;
        rst_i = 1'b1;
        mem_i = 2'b00;
        addr_i = 32'h0;
        wdata_i = 32'h0;
        rst1 = 1'b1;
        mem1 = 2'b00;
        addr1 = 32'h0;
        wdata1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
`ifdef DMEM_STATS_EN
        chk("rst_rd_cnt", rd_cnt_o, 32'd0);
        chk("rst_wr_cnt", wr_cnt_o, 32'd0);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
        step();

        issue(2'b01, 32'h10, 32'hDEADBEEF);
        issue(2'b10, 32'h10, 32'h0);
        step();
        issue(2'b01, 32'h3FC, 32'h11111111);
        issue(2'b01, 32'h7FC, 32'h22222222);
        issue(2'b10, 32'h3FC, 32'h0);
        issue(2'b10, 32'h13, 32'h0);
        issue(2'b11, 32'h20, 32'h5A5A5A5A);
        issue(2'b10, 32'h20, 32'h0);

        // Abort a store with reset while BUSY.
        issue(2'b01, 32'h40, 32'h12345678);
        mem_i = 2'b01;
        addr_i = 32'h40;
        wdata_i = 32'hCAFEF00D;
        step();
        rst_i = 1'b1;
        @(negedge clk);
        chk("abort_stall_rst", 32'(stall_o), 32'd0);
        step();
        rst_i = 1'b0;
        mem_i = 2'b00;
        mdl_rdata = 32'h0;
        mdl_rdata_known = 1'b1;
        @(negedge clk);
        chk("abort_stall", 32'(stall_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_rdata", rdata_o, 32'h0);
`ifdef DMEM_STATS_EN
        chk("abort_rd_cnt", rd_cnt_o, 32'd0);
        chk("abort_wr_cnt", wr_cnt_o, 32'd0);
        chk("abort_stall_cnt", stall_cnt_o, 32'd0);
`endif
        step();
        issue(2'b10, 32'h40, 32'h0);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(op, a, $urandom);
            repeat ($urandom_range(0, 2)) step();
        end

`ifdef DMEM_STATS_EN
        chk("end_rd_cnt", rd_cnt_o, 32'(mdl_rd));
        chk("end_wr_cnt", wr_cnt_o, 32'(mdl_wr));
        chk("end_stall_cnt", stall_cnt_o, 32'(LAT * (mdl_rd + mdl_wr)));
`endif
        chk("queue_empty", 32'(q.size()), 32'd0);

        // LATENCY = 1 instance: one stall cycle, then DONE, then IDLE.
        mem1 = 2'b10;
        addr1 = 32'h0;
        @(negedge clk);
        chk("l1_stall_t0", 32'(stall1), 32'd1);
        chk("l1_done_t0", 32'(done1), 32'd0);
        step();
        @(negedge clk);
        chk("l1_stall_t1", 32'(stall1), 32'd0);
        chk("l1_done_t1", 32'(done1), 32'd1);
        step();
        @(negedge clk);
        chk("l1_done_t2", 32'(done1), 32'd0);
        chk("l1_stall_t2", 32'(stall1), 32'd1);
        step();
        mem1 = 2'b00;
        @(negedge clk);
        chk("l1_done_t3", 32'(done1), 32'd1);
        step();
        @(negedge clk);
        chk("l1_done_t4", 32'(done1), 32'd0);
        chk("l1_stall_t4", 32'(stall1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
